// File: rtl/pll_loop_tuner.sv
// pll_loop_tuner: steps a PLL through loop-filter profiles until it holds a qualified lock
// Ports: clkin/reset (sync, active-high); pll_lock_i raw asynchronous lock;
//   pll_reset, icpsel, lpfres, lpfcap drive the PLL; req_valid/req_profile/req_ready
//   select a profile from LOCKED or FAIL; locked, fail, busy, profile_idx and
//   relock_count report status.
module pll_loop_tuner #(
    parameter int                         NUM_PROFILES  = 4,
    parameter logic [NUM_PROFILES*11-1:0] PROFILE_TABLE = '0,
    parameter int                         RST_CYCLES    = 16,
    parameter int                         LOCK_TIMEOUT  = 65536,
    parameter int                         STABLE_CYCLES = 1024
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock_i,
    output logic       pll_reset,
    output logic [5:0] icpsel,
    output logic [2:0] lpfres,
    output logic [1:0] lpfcap,
    input  logic       req_valid,
    input  logic [3:0] req_profile,
    output logic       req_ready,
    output logic       locked,
    output logic       fail,
    output logic       busy,
    output logic [3:0] profile_idx,
    output logic [7:0] relock_count
);
    typedef enum logic [2:0] {ST_APPLY, ST_RESET, ST_WAIT_LOCK, ST_QUALIFY, ST_LOCKED, ST_FAIL} state_t;
    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  att_q, att_d;
    logic [3:0]  prof_q, prof_d, prof_inc;
    logic [7:0]  relock_q, relock_d;
    logic [10:0] cfg_q, cfg_d;
    logic        lock, accept, advance, exhausted;

    assign lock         = sync_q[1];
    assign req_ready    = state_q == ST_LOCKED || state_q == ST_FAIL;
    assign accept       = req_valid && req_ready && 32'(req_profile) < NUM_PROFILES;
    assign exhausted    = 32'(att_q) + 32'd1 == NUM_PROFILES;
    assign prof_inc     = 32'(prof_q) + 32'd1 == NUM_PROFILES ? 4'd0 : prof_q + 4'd1;
    assign pll_reset    = state_q inside {ST_APPLY, ST_RESET, ST_FAIL};
    assign busy         = state_q inside {ST_APPLY, ST_RESET, ST_WAIT_LOCK, ST_QUALIFY};
    assign locked       = state_q == ST_LOCKED;
    assign fail         = state_q == ST_FAIL;
    assign {icpsel, lpfres, lpfcap} = cfg_q;
    assign profile_idx  = prof_q;
    assign relock_count = relock_q;

    always_comb begin
        state_d  = state_q;
        prof_d   = prof_q;
        att_d    = att_q;
        relock_d = relock_q;
        advance  = 1'b0;
        case (state_q)
            ST_APPLY:     state_d = ST_RESET;
            ST_RESET:     state_d = cnt_q == 32'(RST_CYCLES - 1) ? ST_WAIT_LOCK : ST_RESET;
            ST_WAIT_LOCK: begin
                state_d = lock ? ST_QUALIFY : ST_WAIT_LOCK;
                advance = !lock && cnt_q == 32'(LOCK_TIMEOUT - 1);
            end
            ST_QUALIFY: begin
                advance = !lock;
                if (lock && cnt_q == 32'(STABLE_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                    att_d   = '0;
                end
            end
            ST_LOCKED: if (!lock) begin
                state_d  = ST_APPLY;
                att_d    = '0;
                relock_d = relock_q == 8'hFF ? relock_q : relock_q + 8'd1;
            end
            default: ;
        endcase
        // Out of profiles: stay on the last one tried and park in FAIL.
        if (advance) begin
            att_d   = att_q + 5'd1;
            state_d = exhausted ? ST_FAIL : ST_APPLY;
            prof_d  = exhausted ? prof_q : prof_inc;
        end
        // An accepted request overrides a simultaneous lock loss, so no relock is counted.
        if (accept) begin
            state_d  = ST_APPLY;
            prof_d   = req_profile;
            att_d    = '0;
            relock_d = relock_q;
        end
        cnt_d = state_d == state_q ? cnt_q + 32'd1 : '0;
        // Loop-filter settings move only on the edge entering APPLY, where pll_reset is already high.
        cfg_d = state_d == ST_APPLY ? PROFILE_TABLE[32'(prof_d) * 11 +: 11] : cfg_q;
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q  <= ST_APPLY;
            sync_q   <= '0;
            cnt_q    <= '0;
            att_q    <= '0;
            prof_q   <= '0;
            relock_q <= '0;
            cfg_q    <= PROFILE_TABLE[10:0];
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], pll_lock_i};
            cnt_q    <= cnt_d;
            att_q    <= att_d;
            prof_q   <= prof_d;
            relock_q <= relock_d;
            cfg_q    <= cfg_d;
        end
    end
endmodule

// File: tb/tb_pll_loop_tuner.sv
// tb_pll_loop_tuner: directed and random checks of pll_loop_tuner against a behavioural model
module tb_pll_loop_tuner;
    localparam int NP = 3, RC = 4, LT = 20, SC = 8;
    localparam logic [10:0] E0 = 11'h139, E1 = 11'h2C6, E2 = 11'h5A3;
    localparam logic [32:0] TBL = {E2, E1, E0};

    logic       clkin = 1'b0, reset = 1'b1, pll_lock_i = 1'b0, req_valid = 1'b0;
    logic [3:0] req_profile = '0;
    logic       pll_reset, req_ready, locked, fail, busy;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
    logic [3:0] profile_idx;
    logic [7:0] relock_count;

    pll_loop_tuner #(.NUM_PROFILES(NP), .PROFILE_TABLE(TBL), .RST_CYCLES(RC),
                     .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC)) dut (
        .clkin(clkin), .reset(reset), .pll_lock_i(pll_lock_i), .pll_reset(pll_reset),
        .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap), .req_valid(req_valid),
        .req_profile(req_profile), .req_ready(req_ready), .locked(locked), .fail(fail),
        .busy(busy), .profile_idx(profile_idx), .relock_count(relock_count));

    always #5 clkin = ~clkin;

    int total = 0, bad = 0;
    // Model: mode 0 = reset pulse, 1 = waiting, 2 = qualifying, 3 = locked, 4 = failed.
    logic [10:0] tab [NP] = '{E0, E1, E2};
    int m_mode = 0, m_left = RC + 1, m_cnt = 0, m_prof = 0, m_att = 0, m_relock = 0;
    logic [10:0] m_cfg = E0;
    bit dly[$] = '{0, 0};
    logic [10:0] prev_cfg = 'x;
    int run = 0, last_pulse = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_start(input int p);
        m_prof = p;
        m_cfg  = tab[p];
        m_mode = 0;
        m_left = RC + 1;
    endtask

    task automatic m_adv;
        m_att++;
        if (m_att == NP) m_mode = 4;
        else m_start((m_prof + 1) % NP);
    endtask

    task automatic m_step;
        bit lk;
        if (reset) begin
            m_start(0);
            m_att = 0;
            m_relock = 0;
            dly = '{0, 0};
            return;
        end
        lk = dly.pop_front();
        dly.push_back(pll_lock_i);
        if (req_valid && m_mode >= 3 && req_profile < NP) begin
            m_att = 0;
            m_start(int'(req_profile));
            return;
        end
        case (m_mode)
            0: begin m_left--; if (m_left == 0) begin m_mode = 1; m_cnt = 0; end end
            1: if (lk) begin m_mode = 2; m_cnt = 0; end
               else begin m_cnt++; if (m_cnt == LT) m_adv(); end
            2: if (!lk) m_adv();
               else begin m_cnt++; if (m_cnt == SC) begin m_mode = 3; m_att = 0; end end
            3: if (!lk) begin if (m_relock < 255) m_relock++; m_att = 0; m_start(m_prof); end
            default: ;
        endcase
    endtask

    task automatic cyc;
        @(posedge clkin);
        m_step();
        #1;
        chk("pll_reset", pll_reset, m_mode == 0 || m_mode == 4);
        chk("busy", busy, m_mode <= 2);
        chk("locked", locked, m_mode == 3);
        chk("fail", fail, m_mode == 4);
        chk("req_ready", req_ready, m_mode >= 3);
        chk("profile_idx", profile_idx, m_prof);
        chk("cfg", {icpsel, lpfres, lpfcap}, m_cfg);
        chk("relock_count", relock_count, m_relock);
        if ({icpsel, lpfres, lpfcap} !== prev_cfg) chk("cfg_change_in_reset", pll_reset, 1);
        prev_cfg = {icpsel, lpfres, lpfcap};
        if (pll_reset) run++;
        else begin
            if (run > 0) last_pulse = run;
            run = 0;
        end
    endtask

    task automatic wait_locked(input int max, input string tag);
        int n = 0;
        while (locked !== 1'b1 && n < max) begin cyc(); n++; end
        chk(tag, locked, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, n, hold;
        int seq[$];
        // Reset state
        reset = 1;
        repeat (3) cyc();
        chk("rst_prof", profile_idx, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_cfg", {icpsel, lpfres, lpfcap}, E0);
        // Normal lock: lock raised 10 cycles after release
        reset = 0;
        repeat (10) cyc();
        pll_lock_i = 1;
        rise = -1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (locked === 1'b1 && rise < 0) rise = i;
        end
        chk("lock_latency", rise, 10);
        chk("lock_prof", profile_idx, 0);
        chk("lock_busy", busy, 0);
        // Relock after a 3-cycle drop
        pll_lock_i = 0;
        repeat (3) cyc();
        pll_lock_i = 1;
        wait_locked(40, "relock1");
        chk("relock1_count", relock_count, 1);
        chk("relock1_prof", profile_idx, 0);
        chk("relock1_pulse", last_pulse, RC + 1);
        // Request on the same edge the lock loss is seen
        pll_lock_i = 0;
        cyc();
        cyc();
        req_valid = 1;
        req_profile = 1;
        cyc();
        req_valid = 0;
        chk("simul_relock", relock_count, 1);
        chk("simul_prof", profile_idx, 1);
        pll_lock_i = 1;
        wait_locked(40, "simul_lock");
        // Saturation of relock_count
        repeat (300) begin
            pll_lock_i = 0;
            repeat (3) cyc();
            pll_lock_i = 1;
            wait_locked(40, "relock_loop");
        end
        chk("relock_sat", relock_count, 255);
        chk("relock_sat_prof", profile_idx, 1);
        // Profile advance to FAIL
        reset = 1;
        pll_lock_i = 0;
        repeat (2) cyc();
        reset = 0;
        n = 0;
        while (fail !== 1'b1 && n < 120) begin
            cyc();
            n++;
            if (pll_reset && busy && (seq.size() == 0 || seq[$] != int'(profile_idx))) seq.push_back(int'(profile_idx));
        end
        chk("fail_flag", fail, 1);
        chk("fail_ready", req_ready, 1);
        chk("fail_seq_len", seq.size(), 3);
        foreach (seq[i]) chk("fail_seq", seq[i], i);
        // Out-of-range request ignored, then valid request recovers
        req_valid = 1;
        req_profile = 5;
        cyc();
        req_valid = 0;
        chk("bad_req_fail", fail, 1);
        chk("bad_req_prof", profile_idx, 2);
        repeat (3) cyc();
        req_valid = 1;
        req_profile = 2;
        pll_lock_i = 1;
        cyc();
        req_valid = 0;
        chk("req_fail_clr", fail, 0);
        chk("req_prof", profile_idx, 2);
        chk("req_cfg", {icpsel, lpfres, lpfcap}, E2);
        wait_locked(40, "req_lock");
        // Qualify glitch moves to profile 1
        reset = 1;
        pll_lock_i = 0;
        repeat (2) cyc();
        reset = 0;
        repeat (8) cyc();
        pll_lock_i = 1;
        repeat (5) cyc();
        pll_lock_i = 0;
        cyc();
        pll_lock_i = 1;
        wait_locked(60, "glitch_lock");
        chk("glitch_prof", profile_idx, 1);
        // Reset during QUALIFY of profile 1
        pll_lock_i = 0;
        repeat (3) cyc();
        pll_lock_i = 1;
        n = 0;
        while (pll_reset !== 1'b0 && n < 20) begin cyc(); n++; end
        cyc();
        cyc();
        chk("mr_pre_relock", relock_count, 1);
        reset = 1;
        cyc();
        chk("mr_prof", profile_idx, 0);
        chk("mr_pll_reset", pll_reset, 1);
        chk("mr_locked", locked, 0);
        chk("mr_relock", relock_count, 0);
        reset = 0;
        // Random lock behaviour, requests and occasional resets
        hold = 0;
        repeat (3000) begin
            if (hold == 0) begin
                pll_lock_i = $urandom_range(0, 3) != 0;
                hold = $urandom_range(1, 40);
            end
            hold--;
            req_valid = $urandom_range(0, 15) == 0;
            req_profile = 4'($urandom_range(0, 5));
            reset = $urandom_range(0, 599) == 0;
            cyc();
        end
        reset = 0;
        req_valid = 0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_loop_tuner.md
PLL_LOOP_TUNER -- requirements
Module: pll_loop_tuner

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_PROFILES, 4: number of loop-filter profiles, range 1..16.
- PROFILE_TABLE, 0: NUM_PROFILES x 11-bit packed table; entry k = {icpsel[5:0], lpfres[2:0], lpfcap[1:0]} at bits [11k+10:11k].
- RST_CYCLES, 16: cycles pll_reset is held in the RESET state, minimum 1.
- LOCK_TIMEOUT, 65536: maximum WAIT_LOCK cycles before the current profile is abandoned.
- STABLE_CYCLES, 1024: consecutive synced-lock cycles required to declare lock.

REQ-002 Ports (name, direction, width, meaning):
- clkin, in, 1: free-running reference clock; the block's only clock.
- reset, in, 1: synchronous, active-high reset.
- pll_lock_i, in, 1: raw PLL lock, asynchronous to clkin.
- pll_reset, out, 1: PLL reset.
- icpsel, out, 6: dynamic charge-pump current select.
- lpfres, out, 3: dynamic loop-filter resistor select.
- lpfcap, out, 2: dynamic loop-filter capacitor select.
- req_valid, in, 1: request to tune to a specific profile.
- req_profile, in, 4: requested profile index.
- req_ready, out, 1: request acceptance window.
- locked, out, 1: qualified stable lock.
- fail, out, 1: all profiles exhausted without lock.
- busy, out, 1: tuning in progress.
- profile_idx, out, 4: currently applied profile.
- relock_count, out, 8: saturating count of lock-loss events.

Function
REQ-003 pll_lock_i SHALL pass through a 2-flop synchronizer; "lock" below means the synchronized value (2-cycle latency).
REQ-004 The FSM SHALL have states APPLY, RESET, WAIT_LOCK, QUALIFY, LOCKED and FAIL.
REQ-005 APPLY (1 cycle): load icpsel/lpfres/lpfcap from the PROFILE_TABLE entry profile_idx; go to RESET.
REQ-006 RESET: hold for RST_CYCLES cycles, then go to WAIT_LOCK. pll_reset SHALL be 1 exactly in APPLY and RESET, for RST_CYCLES+1 cycles in total.
REQ-007 icpsel, lpfres and lpfcap SHALL change only on the APPLY-entry edge, never while pll_reset=0.
REQ-008 WAIT_LOCK: when lock=1, go to QUALIFY. After LOCK_TIMEOUT cycles with lock=0, perform the profile advance defined in REQ-011.
REQ-009 QUALIFY: after lock=1 for STABLE_CYCLES consecutive cycles, go to LOCKED. If lock=0 before then, perform the profile advance.
REQ-010 LOCKED: locked=1. If lock=0, increment relock_count (saturating at 255), keep profile_idx, go to APPLY, and reset the attempt counter.
REQ-011 Profile advance:
- Increment the attempt counter.
- If attempts == NUM_PROFILES, go to FAIL.
- Otherwise set profile_idx = (profile_idx+1) mod NUM_PROFILES (wraps to 0) and go to APPLY.
REQ-012 The attempt counter SHALL clear on entry to LOCKED and on request accept.
REQ-013 FAIL: fail=1, pll_reset=1; hold until reset or an accepted request.
REQ-014 req_ready SHALL be 1 only in LOCKED or FAIL.
- Accept when req_valid & req_ready & req_profile < NUM_PROFILES: set profile_idx = req_profile, clear fail, go to APPLY next cycle.
- An out-of-range req_profile SHALL be ignored (no state change).
REQ-015 If a request is accepted in LOCKED in the same cycle as lock=0, the request wins and relock_count SHALL NOT increment.
REQ-016 busy SHALL be 1 in APPLY, RESET, WAIT_LOCK and QUALIFY, and 0 otherwise. locked SHALL be 1 only in LOCKED.

Reset
REQ-017 reset is synchronous and active-high and SHALL override all other inputs.
REQ-018 Reset values:
- state = APPLY, profile_idx = 0, attempts = 0.
- pll_reset = 1; icpsel/lpfres/lpfcap = table entry 0.
- locked = 0, fail = 0, busy = 1, req_ready = 0, relock_count = 0, synchronizer = 0.
REQ-019 reset asserted mid-tuning or mid-LOCKED SHALL restart the sequence from APPLY with profile 0 on release.

Verification
Parameters for all scenarios: NUM_PROFILES=3, RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
REQ-020 Normal lock: release reset, drive pll_lock_i=1 from cycle 10 -> pll_reset high for exactly 5 cycles; locked rises 2+8 cycles after the lock edge; profile_idx=0; busy=0.
REQ-021 Profile advance and fail: hold pll_lock_i=0 -> profile_idx steps 0,1,2, each with a fresh 5-cycle pll_reset pulse and outputs changing only while pll_reset=1; fail=1 after the third timeout; req_ready=1.
REQ-022 Qualify glitch: lock high for 5 cycles, low for 1, then high -> advance to profile 1, locked=0 until profile 1 qualifies.
REQ-023 Relock: in LOCKED, drop lock for 3 cycles -> relock_count=1, profile_idx unchanged, new 5-cycle reset pulse, relock. Repeat 300 times -> relock_count saturates at 255.
REQ-024 Requests:
- In FAIL, req_valid=1 with req_profile=2 -> fail clears, profile 2 applied, lock achieved.
- req_profile=5 -> ignored.
- A request simultaneous with lock loss -> relock_count unchanged.
REQ-025 Mid-operation reset: assert reset during QUALIFY of profile 1 -> next cycle profile_idx=0, pll_reset=1, locked=0, relock_count=0.
